// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: FSM state encoding and the
// selection-mode constants.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2
   } arb_state_t;

   localparam int RR_MODE_FIXED = 0;
   localparam int RR_MODE_ROUND = 1;

endpackage

// File: rtl/mem_port_arbiter_rr_select.sv
// Combinational winner pick: first pending client at or after a base index,
// wrapping; the base is rr_ptr in round-robin mode and 0 in fixed-priority mode.
module rr_select #(
   parameter int N_REQ = 2,
   parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] pending,
   input  logic [ID_W-1:0]  rr_ptr,
   input  logic             rr_mode,
   output logic [ID_W-1:0]  winner,
   output logic             valid
);

   logic [ID_W-1:0] base;
   int              idx;

   assign base  = rr_mode ? rr_ptr : '0;
   assign valid = |pending;

   // Scan offsets from farthest to nearest so the nearest pending client is kept.
   always_comb begin
      winner = '0;
      idx    = 0;
      for (int off = N_REQ - 1; off >= 0; off--) begin
         idx = int'(base) + off;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (pending[idx]) winner = ID_W'(idx);
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one AXI memory port among N_REQ cache controllers with ownership
// tracking, owner-only completion routing and a hung-transaction watchdog.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int N_REQ   = 2,
   parameter int RR_MODE = 1,
   parameter int TIMEOUT = 1024,
   parameter int ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic             clk,
   input  logic             arstn,
   input  logic [N_REQ-1:0] i_rd_req,
   input  logic [N_REQ-1:0] i_wr_req,
   input  logic             i_read_last_axi,
   input  logic             i_b_resp_axi,
   output logic             o_start_read_axi,
   output logic             o_start_write_axi,
   output logic [N_REQ-1:0] o_r_last,
   output logic [N_REQ-1:0] o_b_resp,
   output logic [ID_W-1:0]  o_owner,
   output logic             o_busy,
   output logic             o_timeout
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   arb_state_t       state_reg, state_next;
   logic [ID_W-1:0]  owner_reg, owner_next;
   logic [ID_W-1:0]  rr_ptr_reg, rr_ptr_next;
   logic [CNT_W-1:0] wd_cnt_reg, wd_cnt_next, wd_cnt_inc;
   logic             timeout_reg, timeout_next;
   logic [ID_W-1:0]  sel_winner, ptr_inc;
   logic             sel_valid, wd_hit;

   rr_select #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr_select (
      .pending (i_rd_req | i_wr_req),
      .rr_ptr  (rr_ptr_reg),
      .rr_mode (RR_MODE != RR_MODE_FIXED),
      .winner  (sel_winner),
      .valid   (sel_valid)
   );

   assign ptr_inc    = (int'(sel_winner) >= N_REQ - 1) ? '0 : sel_winner + 1'b1;
   // Counter saturates at TIMEOUT; the hit fires on the TIMEOUT-th busy cycle.
   assign wd_cnt_inc = (int'(wd_cnt_reg) < TIMEOUT) ? wd_cnt_reg + 1'b1 : wd_cnt_reg;
   assign wd_hit     = (TIMEOUT != 0) && (int'(wd_cnt_reg) >= TIMEOUT - 1);

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         state_reg   <= IDLE;
         owner_reg   <= '0;
         rr_ptr_reg  <= '0;
         wd_cnt_reg  <= '0;
         timeout_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         owner_reg   <= owner_next;
         rr_ptr_reg  <= rr_ptr_next;
         wd_cnt_reg  <= wd_cnt_next;
         timeout_reg <= timeout_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      owner_next   = owner_reg;
      rr_ptr_next  = rr_ptr_reg;
      timeout_next = timeout_reg;
      wd_cnt_next  = '0;
      case (state_reg)
         IDLE: begin
            if (sel_valid) begin
               owner_next  = sel_winner;
               rr_ptr_next = (RR_MODE != RR_MODE_FIXED) ? ptr_inc : '0;
               // Dirty block goes out before the refill for the same client.
               state_next  = i_wr_req[sel_winner] ? WRITE : READ;
            end
         end
         READ: begin
            wd_cnt_next = wd_cnt_inc;
            if (i_read_last_axi) begin
               state_next = IDLE;
            end else if (wd_hit) begin
               state_next   = IDLE;
               timeout_next = 1'b1;
            end
         end
         WRITE: begin
            wd_cnt_next = wd_cnt_inc;
            if (i_b_resp_axi) begin
               state_next = IDLE;
            end else if (wd_hit) begin
               state_next   = IDLE;
               timeout_next = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_route
      assign o_r_last[gi] = (state_reg == READ)  && (owner_reg == ID_W'(gi)) && i_read_last_axi;
      assign o_b_resp[gi] = (state_reg == WRITE) && (owner_reg == ID_W'(gi)) && i_b_resp_axi;
   end

   assign o_start_read_axi  = (state_reg == READ);
   assign o_start_write_axi = (state_reg == WRITE);
   assign o_busy            = (state_reg != IDLE);
   assign o_owner           = owner_reg;
   assign o_timeout         = timeout_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: a 2-client round-robin arbiter (watchdog 8) and a 4-client
// fixed-priority arbiter, checked against hand-computed expectations.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   logic arstn = 1'b0;

   logic [1:0] a_rd = '0, a_wr = '0;
   logic       a_rl = 1'b0, a_br = 1'b0;
   logic       a_sr, a_sw, a_busy, a_to;
   logic [1:0] a_rlast, a_bresp;
   logic [0:0] a_owner;

   logic [3:0] b_rd = '0, b_wr = '0;
   logic       b_rl = 1'b0, b_br = 1'b0;
   logic       b_sr, b_sw, b_busy, b_to;
   logic [3:0] b_rlast, b_bresp;
   logic [1:0] b_owner;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.N_REQ(2), .RR_MODE(1), .TIMEOUT(8)) dut_a (
      .clk(clk), .arstn(arstn), .i_rd_req(a_rd), .i_wr_req(a_wr),
      .i_read_last_axi(a_rl), .i_b_resp_axi(a_br),
      .o_start_read_axi(a_sr), .o_start_write_axi(a_sw),
      .o_r_last(a_rlast), .o_b_resp(a_bresp), .o_owner(a_owner),
      .o_busy(a_busy), .o_timeout(a_to)
   );

   mem_port_arbiter #(.N_REQ(4), .RR_MODE(0), .TIMEOUT(8)) dut_b (
      .clk(clk), .arstn(arstn), .i_rd_req(b_rd), .i_wr_req(b_wr),
      .i_read_last_axi(b_rl), .i_b_resp_axi(b_br),
      .o_start_read_axi(b_sr), .o_start_write_axi(b_sw),
      .o_r_last(b_rlast), .o_b_resp(b_bresp), .o_owner(b_owner),
      .o_busy(b_busy), .o_timeout(b_to)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n_read;
      int guard;

      #1;
      check("rst_start_read", a_sr, 0);
      check("rst_busy", a_busy, 0);
      check("rst_owner", a_owner, 0);
      check("rst_timeout", a_to, 0);
      step();
      arstn = 1'b1;
      step();

      // Round-robin: both clients read continuously, owners alternate.
      a_rd = 2'b11;
      for (int g = 0; g < 4; g++) begin
         step();
         check("rr_owner", a_owner, g % 2);
         check("rr_start_read", a_sr, 1);
         repeat (3) step();
         a_rl = 1'b1;
         if (g == 3) a_rd = 2'b00;
         #1;
         check("rr_r_last_route", a_rlast, (g % 2) ? 2'b10 : 2'b01);
         step();
         a_rl = 1'b0;
         check("rr_idle_gap", a_sr, 0);
      end

      // Write beats read for the same client; stray read_last ignored in WRITE.
      a_wr = 2'b10;
      a_rd = 2'b10;
      step();
      check("wr_first_sw", a_sw, 1);
      check("wr_first_sr", a_sr, 0);
      check("wr_owner", a_owner, 1);
      a_rl = 1'b1;
      #1;
      check("wr_stray_rlast", a_rlast, 2'b00);
      step();
      a_rl = 1'b0;
      check("wr_stray_keep", a_sw, 1);
      a_br = 1'b1;
      #1;
      check("wr_b_resp_route", a_bresp, 2'b10);
      step();
      a_br = 1'b0;
      a_wr = 2'b00;
      check("wr_done_busy", a_busy, 0);
      step();
      check("wr_then_read", a_sr, 1);
      check("wr_then_read_owner", a_owner, 1);
      a_br = 1'b1;
      #1;
      check("rd_stray_bresp", a_bresp, 2'b00);
      step();
      a_br = 1'b0;
      check("rd_stray_keep", a_sr, 1);
      a_rl = 1'b1;
      a_rd = 2'b00;
      #1;
      check("rd_r_last_route", a_rlast, 2'b10);
      step();
      a_rl = 1'b0;
      check("rd_done_busy", a_busy, 0);

      // Completion inputs in IDLE are not routed.
      a_rl = 1'b1;
      a_br = 1'b1;
      #1;
      check("idle_rlast", a_rlast, 2'b00);
      check("idle_bresp", a_bresp, 2'b00);
      step();
      a_rl = 1'b0;
      a_br = 1'b0;
      check("idle_stay", a_busy, 0);

      // Completion on the same cycle as the watchdog limit wins.
      a_rd = 2'b01;
      step();
      check("coin_owner", a_owner, 0);
      a_rd = 2'b00;
      repeat (7) step();
      check("coin_still_read", a_sr, 1);
      a_rl = 1'b1;
      #1;
      check("coin_rlast", a_rlast, 2'b01);
      step();
      a_rl = 1'b0;
      check("coin_idle", a_busy, 0);
      check("coin_no_timeout", a_to, 0);

      // Watchdog: owner drops request, no completion, exactly 8 READ cycles.
      a_rd = 2'b01;
      step();
      a_rd = 2'b00;
      n_read = a_sr ? 1 : 0;
      guard = 0;
      while (a_sr && guard < 20) begin
         step();
         if (a_sr) n_read++;
         guard++;
      end
      check("wd_read_cycles", n_read, 8);
      check("wd_timeout_set", a_to, 1);
      check("wd_idle", a_busy, 0);
      a_rd = 2'b10;
      step();
      check("wd_next_grant", a_sr, 1);
      check("wd_next_owner", a_owner, 1);
      a_rl = 1'b1;
      a_rd = 2'b00;
      #1;
      check("wd_next_rlast", a_rlast, 2'b10);
      step();
      a_rl = 1'b0;
      check("wd_sticky", a_to, 1);

      // Reset mid-WRITE: outputs drop at once, rr_ptr returns to 0.
      a_wr = 2'b01;
      step();
      check("rst_mid_write_sw", a_sw, 1);
      a_wr = 2'b00;
      step();
      a_br = 1'b1;
      arstn = 1'b0;
      #1;
      check("arst_sw", a_sw, 0);
      check("arst_busy", a_busy, 0);
      check("arst_bresp", a_bresp, 2'b00);
      check("arst_owner", a_owner, 0);
      check("arst_timeout", a_to, 0);
      a_br = 1'b0;
      step();
      arstn = 1'b1;
      a_rd = 2'b11;
      step();
      check("post_rst_owner", a_owner, 0);
      check("post_rst_sr", a_sr, 1);
      a_rl = 1'b1;
      a_rd = 2'b10;
      step();
      a_rl = 1'b0;
      step();
      check("post_rst_client1", a_owner, 1);
      a_rl = 1'b1;
      a_rd = 2'b00;
      step();
      a_rl = 1'b0;

      // Fixed priority, 4 clients: client 2 always beats client 3.
      b_rd = 4'b1100;
      for (int g = 0; g < 3; g++) begin
         step();
         check("fp_owner", b_owner, 2);
         check("fp_start_read", b_sr, 1);
         step();
         b_rl = 1'b1;
         if (g == 2) b_rd = 4'b0000;
         #1;
         check("fp_r_last_route", b_rlast, 4'b0100);
         step();
         b_rl = 1'b0;
         check("fp_idle_gap", b_busy, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Parametrised arbiter that shares one AXI memory port among `N_REQ` cache controllers. It generalises the fixed two-client scheme, where instruction and data read starts were simply OR-ed, into an arbitrated, ownership-tracked port with the following behaviour:
- per-client read and write-back requests;
- round-robin or fixed-priority selection;
- completion routing back to the owning client only;
- a watchdog that releases the port on a hung transaction.

It sits in the control unit between the cache FSMs and the AXI master.

## Interface
Parameters:
- `N_REQ`, 2: number of client cache controllers (≥1).
- `RR_MODE`, 1: 1 = round-robin; 0 = fixed priority, where the lowest index wins.
- `TIMEOUT`, 1024: watchdog limit in cycles; 0 disables the watchdog.
- `ID_W`, derived: max(1, $clog2(N_REQ)).

Ports:
- `clk` in 1: the single clock.
- `arstn` in 1: reset, asynchronous and active-low.
- `i_rd_req` in N_REQ: per-client read request, held until completion.
- `i_wr_req` in N_REQ: per-client write-back request, held until completion.
- `i_read_last_axi` in 1: last read beat from the AXI master.
- `i_b_resp_axi` in 1: write response from the AXI master.
- `o_start_read_axi` out 1: read transaction active.
- `o_start_write_axi` out 1: write transaction active.
- `o_r_last` out N_REQ: `i_read_last_axi` routed to the owner only.
- `o_b_resp` out N_REQ: `i_b_resp_axi` routed to the owner only.
- `o_owner` out ID_W: index of the current owner.
- `o_busy` out 1: port owned (READ or WRITE state).
- `o_timeout` out 1: sticky watchdog flag.

## Operation
States: IDLE, READ, WRITE (enum in package).

IDLE:
- A client is pending if `i_rd_req[k] | i_wr_req[k]`.
- If any client is pending, select a winner:
  - RR_MODE=1: first pending index at or after `rr_ptr`, wrapping modulo N_REQ.
  - RR_MODE=0: lowest pending index.
- Register the winner in `o_owner`.
- If the winner has `i_wr_req` set, go to WRITE; otherwise go to READ. Write beats read for the same client, so the dirty block is written back before the refill.
- In RR mode, `rr_ptr` becomes (winner+1) mod N_REQ. N_REQ=1 always selects client 0.

READ:
- `o_start_read_axi`=1.
- `o_r_last[o_owner]` = `i_read_last_axi`, combinationally.
- On `i_read_last_axi`, go to IDLE.

WRITE:
- `o_start_write_axi`=1.
- `o_b_resp[o_owner]` = `i_b_resp_axi`, combinationally.
- On `i_b_resp_axi`, go to IDLE.

Watchdog:
- Cycle counter is cleared in IDLE and increments in READ/WRITE.
- When it reaches TIMEOUT (TIMEOUT≠0): go to IDLE, set `o_timeout`, and emit no completion pulse.

Boundary rules:
- `i_read_last_axi` / `i_b_resp_axi` in IDLE, or of the wrong kind for the current state: ignored, not routed.
- Owner drops its request mid-transaction: transaction continues to completion; ownership is not revoked.
- Non-owner requests during READ/WRITE: wait; no preemption.
- Completion and watchdog limit in the same cycle: the completion wins, it is routed, and `o_timeout` is not set.
- Watchdog counter saturates; it never wraps.
- `o_timeout` clears only on reset.

## Timing
- Reset (async assert, sync deassert via `arstn`): state=IDLE, rr_ptr=0, counter=0, `o_owner`=0, `o_timeout`=0. All start/route/busy outputs are 0.
- Grant latency: request seen in IDLE at cycle t → state READ/WRITE and `o_start_*_axi`=1 from cycle t+1.
- Completion:
  - `o_r_last` / `o_b_resp` pulse in the same cycle as the AXI input (zero latency).
  - State is IDLE at the next cycle.
- Mandatory IDLE cycle between transactions, so back-to-back grants are spaced by at least one cycle.
- Clients must deassert their request in the cycle after seeing their completion pulse. A request still high in the following IDLE cycle is treated as a new request.
- `o_start_*_axi` are registered-state decodes and glitch-free.

## Structure
- Package `mem_arb_pkg`: the `arb_state_t` enum (IDLE/READ/WRITE) and the `RR_MODE` encoding constants.
- Sub-module `rr_select`: combinational pick. Inputs: pending vector, `rr_ptr`, mode. Outputs: winner index and valid. Parametrised by N_REQ.
- Top holds the FSM, owner register, rr_ptr, watchdog counter and routing.

## Test plan
- N_REQ=2, RR_MODE=1; both clients assert `i_rd_req` continuously; each `i_read_last_axi` is 4 cycles after the grant → owners alternate 0,1,0,1. `o_r_last` pulses only on the owner bit. `o_start_read_axi` has one low IDLE cycle between grants.
- Client 1 asserts `i_wr_req` and `i_rd_req` together → WRITE first; `o_b_resp[1]` routes `i_b_resp_axi`. Then IDLE, then READ for client 1.
- RR_MODE=0, N_REQ=4; clients 2 and 3 request continuously → client 2 always wins and client 3 starves. This is the expected behaviour.
- TIMEOUT=8; grant READ and never assert `i_read_last_axi` → exactly 8 cycles in READ. Then IDLE, `o_timeout`=1 (sticky), no `o_r_last` pulse, and the next request is granted normally.
- `i_read_last_axi` pulsed in IDLE, and `i_b_resp_axi` pulsed during READ → no routed pulse and no state change.
- `arstn` low mid-WRITE → all outputs 0 immediately. After release, state is IDLE, rr_ptr=0, and a pending client 1 with RR_MODE=1 gets the grant.
